// File: rtl/gamma_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// gamma_cycle_sequencer
//
// Runs one gamma cycle of pulse-width-encoded temporal compute. A start
// request latches a vector of spike times. The block then holds the operator
// network in gamma reset (grst) for one cycle. Next it drives each legal input
// as a PULSE_WIDTH-wide pulse beginning at its spike time. It also records
// when the network result line first rises. The first rise is reported as a
// spike time when the cycle ends.
//
// Ports:
//   aclk       clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   start      request to run one gamma cycle (accepted when start & ready)
//   ready      high while idle
//   in_valid   per-input spike-present flags
//   in_time    packed spike times, input i at [i*TW +: TW]
//   grst       gamma reset to the operator network
//   spike      pulse-width-encoded input lines
//   res        result line from the operator network
//   busy       high for the whole gamma cycle
//   done       one-cycle pulse when out_valid/out_time are updated
//   out_valid  res rose during the last gamma cycle
//   out_time   spike time of res, all-ones when out_valid is low
//   err        a valid input carried a time beyond MAX_T
// ---------------------------------------------------------------------------
module gamma_cycle_sequencer #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int N_INPUTS          = 2,
    localparam int TW               = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                   aclk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   ready,
    input  logic [N_INPUTS-1:0]    in_valid,
    input  logic [N_INPUTS*TW-1:0] in_time,
    output logic                   grst,
    output logic [N_INPUTS-1:0]    spike,
    input  logic                   res,
    output logic                   busy,
    output logic                   done,
    output logic                   out_valid,
    output logic [TW-1:0]          out_time,
    output logic                   err
);

    localparam int MAX_T = GAMMA_CYCLE_WIDTH - 1 - PULSE_WIDTH;

    // Spike-window arithmetic is done one bit wider than the counter, because
    // t + PULSE_WIDTH of an illegal time can exceed the counter range.
    localparam logic [TW:0]   MAX_T_X = (TW+1)'(MAX_T);
    localparam logic [TW:0]   PW_X    = (TW+1)'(PULSE_WIDTH);
    localparam logic [TW-1:0] G_LAST  = TW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [TW-1:0] ONE     = TW'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state;
    logic [TW-1:0]            g;
    logic [N_INPUTS-1:0]      lat_valid;
    logic [N_INPUTS*TW-1:0]   lat_time;
    logic                     cap_valid;
    logic [TW-1:0]            cap_time;

    logic [N_INPUTS-1:0]      spike_nx;
    logic                     err_nx;
    logic                     res_hit;
    logic [TW:0]              g_nx;
    logic [TW:0]              t_ext;

    // The spike pattern is evaluated for the next counter value, so the
    // registered spike lines line up with g. A spike at time t is high for
    // g in [t+1, t+PULSE_WIDTH], which puts time 0 at g=1.
    always_comb begin
        spike_nx = '0;
        err_nx   = 1'b0;
        g_nx     = {1'b0, g} + (TW+1)'(1);
        t_ext    = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            t_ext = {1'b0, lat_time[i*TW +: TW]};
            spike_nx[i] = lat_valid[i] && (t_ext <= MAX_T_X) &&
                          (g_nx > t_ext) && (g_nx <= t_ext + PW_X);
            if (in_valid[i] && ({1'b0, in_time[i*TW +: TW]} > MAX_T_X)) begin
                err_nx = 1'b1;
            end
        end
    end

    // The first rise of res wins. Activity during the grst cycle (g=0) is
    // ignored, because the network is still being reset then.
    assign res_hit = (state == RUN) && res && !cap_valid && (g != '0);

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            g         <= '0;
            lat_valid <= '0;
            lat_time  <= '0;
            cap_valid <= 1'b0;
            cap_time  <= '1;
            ready     <= 1'b1;
            grst      <= 1'b1;
            spike     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_time  <= '1;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && ready) begin
                        state     <= RUN;
                        g         <= '0;
                        lat_valid <= in_valid;
                        lat_time  <= in_time;
                        cap_valid <= 1'b0;
                        cap_time  <= '1;
                        err       <= err_nx;
                        grst      <= 1'b1;
                        spike     <= '0;
                        busy      <= 1'b1;
                        ready     <= 1'b0;
                    end
                end
                RUN: begin
                    if (res_hit) begin
                        cap_valid <= 1'b1;
                        cap_time  <= g - ONE;
                    end
                    // The final edge also samples res, so a rise in the last
                    // cycle goes straight to the outputs.
                    if (g == G_LAST) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        grst      <= 1'b1;
                        spike     <= '0;
                        busy      <= 1'b0;
                        ready     <= 1'b1;
                        out_valid <= cap_valid || res_hit;
                        out_time  <= cap_valid ? cap_time :
                                     (res_hit ? g - ONE : '1);
                    end else begin
                        g     <= g + ONE;
                        grst  <= 1'b0;
                        spike <= spike_nx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gamma_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gamma_cycle_sequencer
//
// Directed bench for gamma_cycle_sequencer at default parameters. The result
// line is driven by a small behavioural greater_than, or tied to spike[0], or
// held low. Each vector carries hand-computed spike masks and results.
// ---------------------------------------------------------------------------
module tb_gamma_cycle_sequencer;

    logic       aclk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       ready;
    logic [1:0] in_valid;
    logic [7:0] in_time;
    logic       grst;
    logic [1:0] spike;
    logic       res;
    logic       busy;
    logic       done;
    logic       out_valid;
    logic [3:0] out_time;
    logic       err;

    int testsRun    = 0;
    int testsFailed = 0;

    // 0: greater_than model, 1: res follows spike[0], 2: res held low
    int   resMode = 0;
    logic bInhibit;

    // Results sampled over one gamma cycle (index = cycle after accept - 1)
    logic [15:0] spk0Mask, spk1Mask;
    logic [16:0] doneMask, grstMask, busyMask;
    logic        errAtG0, errAtDone, holdValid, outValidSeen;
    logic [3:0]  holdTime, outTimeSeen;
    logic        prevValid = 1'b0;
    logic [3:0]  prevTime  = 4'hF;

    gamma_cycle_sequencer dut (
        .aclk      (aclk),
        .rst_n     (rst_n),
        .start     (start),
        .ready     (ready),
        .in_valid  (in_valid),
        .in_time   (in_time),
        .grst      (grst),
        .spike     (spike),
        .res       (res),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_time  (out_time),
        .err       (err)
    );

    always #5 aclk = ~aclk;

    // Behavioural greater_than: a (spike[0]) passes only if b (spike[1])
    // has not yet arrived. Once b has been seen, the rest of the gamma cycle
    // is inhibited.
    always_ff @(posedge aclk) begin
        if (grst) bInhibit <= 1'b0;
        else if (spike[1]) bInhibit <= 1'b1;
    end

    always_comb begin
        case (resMode)
            0:       res = spike[0] & ~spike[1] & ~bInhibit;
            1:       res = spike[0];
            default: res = 1'b0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive a start request and sample one full gamma cycle plus the done cycle.
    task automatic applyStimulus(input logic [1:0] v, input logic [3:0] t0,
                                 input logic [3:0] t1, input int m);
        @(negedge aclk);
        resMode = m;
        checkOutput("readyBeforeStart", 32'(ready), 32'd1);
        in_valid = v;
        in_time  = {t1, t0};
        start    = 1'b1;
        spk0Mask = '0; spk1Mask = '0;
        doneMask = '0; grstMask = '0; busyMask = '0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge aclk);
            if (k == 1) begin
                start     = 1'b0;
                in_valid  = 2'b11;
                in_time   = 8'hFF;
                errAtG0   = err;
                holdValid = out_valid;
                holdTime  = out_time;
            end
            if (k <= 16) begin
                spk0Mask[k-1] = spike[0];
                spk1Mask[k-1] = spike[1];
            end
            doneMask[k-1] = done;
            grstMask[k-1] = grst;
            busyMask[k-1] = busy;
            if (k == 17) begin
                errAtDone    = err;
                outValidSeen = out_valid;
                outTimeSeen  = out_time;
            end
        end
        in_valid = '0;
        in_time  = '0;
    endtask

    task automatic checkRun(input string name, input logic [15:0] s0,
                            input logic [15:0] s1, input logic e,
                            input logic ov, input logic [3:0] ot);
        checkOutput({name, ".spike0"},   32'(spk0Mask), 32'(s0));
        checkOutput({name, ".spike1"},   32'(spk1Mask), 32'(s1));
        checkOutput({name, ".done"},     32'(doneMask), 32'h10000);
        checkOutput({name, ".grst"},     32'(grstMask), 32'h10001);
        checkOutput({name, ".busy"},     32'(busyMask), 32'h0FFFF);
        checkOutput({name, ".errG0"},    32'(errAtG0),  32'(e));
        checkOutput({name, ".errDone"},  32'(errAtDone), 32'(e));
        checkOutput({name, ".holdV"},    32'(holdValid), 32'(prevValid));
        checkOutput({name, ".holdT"},    32'(holdTime),  32'(prevTime));
        checkOutput({name, ".outValid"}, 32'(outValidSeen), 32'(ov));
        checkOutput({name, ".outTime"},  32'(outTimeSeen),  32'(ot));
        prevValid = ov;
        prevTime  = ot;
    endtask

    logic [63:0] b2bDone, b2bGrst;
    logic        doneSeen;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = '0;
        in_time  = '0;
        repeat (3) @(negedge aclk);
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstSpike",    32'(spike),     32'd0);
        checkOutput("rstErr",      32'(err),       32'd0);
        rst_n = 1'b1;

        // Idle with start low: nothing moves.
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            checkOutput("idleGrst",    32'(grst),     32'd1);
            checkOutput("idleReady",   32'(ready),    32'd1);
            checkOutput("idleBusy",    32'(busy),     32'd0);
            checkOutput("idleDone",    32'(done),     32'd0);
            checkOutput("idleOutTime", 32'(out_time), 32'hF);
        end

        // t0=2, t1=4: a arrives first, so greater_than fires at g=3 -> time 2.
        applyStimulus(2'b11, 4'd2, 4'd4, 0);
        checkRun("runA", 16'h07F8, 16'h1FE0, 1'b0, 1'b1, 4'd2);

        // t0=0 with res tied to spike[0]: first rise at g=1 -> time 0.
        applyStimulus(2'b01, 4'd0, 4'd3, 1);
        checkRun("runB", 16'h01FE, 16'h0000, 1'b0, 1'b1, 4'd0);

        // t0=9 is illegal: suppressed with err. t1=1 still runs at g=2..9.
        applyStimulus(2'b11, 4'd9, 4'd1, 0);
        checkRun("runC", 16'h0000, 16'h03FC, 1'b1, 1'b0, 4'hF);

        // MAX_T boundary: t1=7 is legal and fills g=8..15. err is cleared.
        applyStimulus(2'b10, 4'd2, 4'd7, 0);
        checkRun("runD", 16'h0000, 16'hFF00, 1'b0, 1'b0, 4'hF);

        // b arrives first, so greater_than is inhibited and there is no result.
        applyStimulus(2'b11, 4'd4, 4'd2, 0);
        checkRun("runE", 16'h1FE0, 16'h07F8, 1'b0, 1'b0, 4'hF);

        // Equal times rise together. res follows spike[0] -> time 3.
        applyStimulus(2'b11, 4'd3, 4'd3, 1);
        checkRun("runF", 16'h0FF0, 16'h0FF0, 1'b0, 1'b1, 4'd3);

        // Start held high: accepts every 17 cycles. grst is high for done + g=0.
        @(negedge aclk);
        resMode  = 0;
        in_valid = 2'b11;
        in_time  = {4'd4, 4'd2};
        start    = 1'b1;
        b2bDone  = '0;
        b2bGrst  = '0;
        for (int k = 1; k <= 51; k++) begin
            @(negedge aclk);
            b2bDone[k-1] = done;
            b2bGrst[k-1] = grst;
            if (k == 51) start = 1'b0;
        end
        checkOutput("b2bDone", 32'(b2bDone[50:0] >> 16), 32'h0000_0000 | 32'((51'h1 | (51'h1 << 17) | (51'h1 << 34))));
        checkOutput("b2bGrstLo", b2bGrst[31:0],  32'h0003_0001);
        checkOutput("b2bGrstHi", 32'(b2bGrst[50:32]), 32'h0004_0006);
        checkOutput("b2bOutTime", 32'(out_time), 32'd2);
        in_valid = '0;
        in_time  = '0;

        // Reset in the middle of a run at g=6.
        @(negedge aclk);
        in_valid = 2'b11;
        in_time  = {4'd4, 4'd2};
        start    = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        repeat (6) @(negedge aclk);
        checkOutput("preRstSpike", 32'(spike), 32'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstSpike",    32'(spike),     32'd0);
        checkOutput("midRstGrst",     32'(grst),      32'd1);
        checkOutput("midRstBusy",     32'(busy),      32'd0);
        checkOutput("midRstDone",     32'(done),      32'd0);
        checkOutput("midRstOutTime",  32'(out_time),  32'hF);
        checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
        checkOutput("midRstReady",    32'(ready),     32'd1);
        repeat (2) @(negedge aclk);
        rst_n    = 1'b1;
        doneSeen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (done) doneSeen = 1'b1;
        end
        checkOutput("postRstNoDone", 32'(doneSeen), 32'd0);
        checkOutput("postRstBusy",   32'(busy),     32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
